// File: rtl/result_wb_arbiter_pkg.sv
// Types shared by the result writeback arbiter: result uop, branch broadcast,
// queue entry, and the branch-kill predicate.
package result_wb_arbiter_pkg;

  localparam int SQN_W   = 7;
  localparam int TAG_W   = 7;
  localparam int RES_W   = 32;
  localparam int FLAGS_W = 4;

  typedef logic [SQN_W-1:0] SqN;

  typedef struct packed {
    logic taken;
    SqN   sqN;
  } BranchProv;

  typedef struct packed {
    logic [RES_W-1:0]   result;
    logic [TAG_W-1:0]   tagDst;
    SqN                 sqN;
    logic [FLAGS_W-1:0] flags;
    logic               doNotCommit;
    logic               valid;
  } RES_UOp;

  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tagDst;
    SqN                 sqN;
    logic [RES_W-1:0]   result;
    logic [FLAGS_W-1:0] flags;
    logic               doNotCommit;
  } res_entry_t;

  // Sequence numbers wrap, so "younger than the branch" is a signed difference.
  function automatic logic killed(input BranchProv br, input SqN sqn);
    SqN diff;
    diff = sqn - br.sqN;
    return br.taken && ($signed(diff) > $signed({SQN_W{1'b0}}));
  endfunction

  function automatic res_entry_t to_entry(input RES_UOp u);
    res_entry_t e;
    e.valid       = 1'b1;
    e.tagDst      = u.tagDst;
    e.sqN         = u.sqN;
    e.result      = u.result;
    e.flags       = u.flags;
    e.doNotCommit = u.doNotCommit;
    return e;
  endfunction

  function automatic RES_UOp to_uop(input res_entry_t e);
    RES_UOp u;
    u.valid       = e.valid;
    u.tagDst      = e.tagDst;
    u.sqN         = e.sqN;
    u.result      = e.result;
    u.flags       = e.flags;
    u.doNotCommit = e.doNotCommit;
    return u;
  endfunction

endpackage

// File: rtl/result_wb_arbiter_chk.sv
// Protocol checker for one result queue: a live result must never arrive at a full queue.
module result_fifo_chk (
  input logic clk,
  input logic rst,
  input logic enq_req_i,
  input logic full_i
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(enq_req_i && full_i))
    else $error("result_fifo: enqueue into full queue, result dropped");

endmodule

// File: rtl/result_wb_arbiter_fifo.sv
// Single-producer result queue with per-entry branch flush, automatic popping of
// flushed heads, and an early-warning busy flag derived from the occupancy count.
module result_fifo
  import result_wb_arbiter_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int BUSY_THRESH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  BranchProv  branch_i,
  input  RES_UOp     uop_i,
  input  logic       grant_i,
  output logic       head_avail_o,
  output res_entry_t head_o,
  output logic       busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  res_entry_t        mem_q [DEPTH];
  res_entry_t        mem_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic              nonempty_s;
  logic              full_s;
  logic              enq_req_s;
  logic              enq_s;
  logic              pop_s;

  // Head visibility, push/pop decisions and next queue state.
  always_comb begin
    head_o       = mem_q[rd_ptr_q];
    nonempty_s   = (count_q != {CW{1'b0}});
    full_s       = (count_q == CW'(DEPTH));
    head_avail_o = nonempty_s && head_o.valid && !killed(branch_i, head_o.sqN);
    // A flushed head leaves without a grant; a live head leaves only when granted.
    pop_s        = nonempty_s && (!head_o.valid || (grant_i && head_avail_o));
    enq_req_s    = uop_i.valid && !killed(branch_i, uop_i.sqN);
    enq_s        = enq_req_s && !full_s;

    for (int e = 0; e < DEPTH; e++) begin
      mem_d[e] = mem_q[e];
      if (killed(branch_i, mem_q[e].sqN)) begin
        mem_d[e].valid = 1'b0;
      end else begin
        mem_d[e].valid = mem_q[e].valid;
      end
    end
    if (pop_s) begin
      mem_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d              = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (enq_s) begin
      mem_d[wr_ptr_q] = to_entry(uop_i);
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    count_d = count_q + CW'(enq_s) - CW'(pop_s);
    busy_o  = (CW'(DEPTH) - count_q) <= CW'(BUSY_THRESH);
  end

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= '0;
      end
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= mem_d[e];
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  result_fifo_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .enq_req_i (enq_req_s),
    .full_i    (full_s)
  );

endmodule

// File: rtl/result_wb_arbiter.sv
// Collects functional-unit results into per-unit queues and drains them round-robin
// onto registered writeback ports.
module result_wb_arbiter
  import result_wb_arbiter_pkg::*;
#(
  parameter int NUM_IN      = 4,
  parameter int NUM_OUT     = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int BUSY_THRESH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  BranchProv           IN_branch,
  input  RES_UOp              IN_uops  [NUM_IN],
  output logic [NUM_IN-1:0]   OUT_busy,
  output RES_UOp              OUT_uops [NUM_OUT]
);

  localparam int RRW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN-1:0] avail_s;
  logic [NUM_IN-1:0] grant_s;
  res_entry_t        head_s [NUM_IN];
  logic [RRW-1:0]    rr_q, rr_d;
  RES_UOp            out_q [NUM_OUT];
  RES_UOp            out_d [NUM_OUT];

  for (genvar i = 0; i < NUM_IN; i++) begin : g_fifo
    result_fifo #(
      .DEPTH       (FIFO_DEPTH),
      .BUSY_THRESH (BUSY_THRESH)
    ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .branch_i     (IN_branch),
      .uop_i        (IN_uops[i]),
      .grant_i      (grant_s[i]),
      .head_avail_o (avail_s[i]),
      .head_o       (head_s[i]),
      .busy_o       (OUT_busy[i])
    );
  end

  // Round-robin scan from rr; the k-th grant in scan order fills output slot k.
  always_comb begin : arb_comb
    int idx;
    int g;
    idx     = 0;
    g       = 0;
    grant_s = {NUM_IN{1'b0}};
    rr_d    = rr_q;
    for (int k = 0; k < NUM_OUT; k++) begin
      out_d[k] = '0;
    end
    for (int k = 0; k < NUM_IN; k++) begin
      idx = (int'(rr_q) + k) % NUM_IN;
      if (avail_s[idx] && (g < NUM_OUT)) begin
        grant_s[idx] = 1'b1;
        out_d[g]     = to_uop(head_s[idx]);
        g            = g + 1;
        rr_d         = RRW'((idx + 1) % NUM_IN);
      end else begin
        rr_d = rr_d;
      end
    end
  end

  // Round-robin pointer and writeback port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= {RRW{1'b0}};
      for (int k = 0; k < NUM_OUT; k++) begin
        out_q[k] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int k = 0; k < NUM_OUT; k++) begin
        out_q[k] <= out_d[k];
      end
    end
  end

  assign OUT_uops = out_q;

endmodule

// File: tb/tb_result_wb_arbiter.sv
// Directed bench for result_wb_arbiter: table-driven single results plus
// hand-walked flush, contention, busy and mid-operation reset sequences.
module tb_result_wb_arbiter;
  import result_wb_arbiter_pkg::*;

  localparam int NI = 4;
  localparam int NO = 2;

  logic            clk = 1'b0;
  logic            rst;
  BranchProv       branch;
  RES_UOp          in_uops  [NI];
  logic [NI-1:0]   busy;
  RES_UOp          out_uops [NO];

  int total = 0;
  int bad   = 0;
  RES_UOp none_c;

  typedef struct {
    int                 idx;
    logic [TAG_W-1:0]   tag;
    SqN                 sqn;
    logic [RES_W-1:0]   res;
    logic [FLAGS_W-1:0] fl;
    logic               dnc;
    logic               br_taken;
    SqN                 br_sqn;
    logic               exp_valid;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  result_wb_arbiter #(
    .NUM_IN      (NI),
    .NUM_OUT     (NO),
    .FIFO_DEPTH  (4),
    .BUSY_THRESH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .IN_branch (branch),
    .IN_uops   (in_uops),
    .OUT_busy  (busy),
    .OUT_uops  (out_uops)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic RES_UOp mk(input logic [TAG_W-1:0] tag, input SqN sqn,
                                input logic [RES_W-1:0] res, input logic [FLAGS_W-1:0] fl,
                                input logic dnc);
    RES_UOp u;
    u.valid       = 1'b1;
    u.tagDst      = tag;
    u.sqN         = sqn;
    u.result      = res;
    u.flags       = fl;
    u.doNotCommit = dnc;
    return u;
  endfunction

  // Result pattern used by the multi-cycle sequences: tag = sqN, result = 0x100 + sqN.
  function automatic RES_UOp ev(input int s);
    return mk(TAG_W'(s), SqN'(s), RES_W'(32'h100 + s), 4'h0, 1'b0);
  endfunction

  task automatic idle();
    for (int i = 0; i < NI; i++) in_uops[i] = '0;
    branch = '0;
  endtask

  task automatic check_slot(input string name, input int slot, input RES_UOp exp);
    if (exp.valid) check(name, 64'(out_uops[slot]), 64'(exp));
    else           check(name, 64'(out_uops[slot].valid), 64'd0);
  endtask

  task automatic check_pair(input string name, input RES_UOp e0, input RES_UOp e1);
    check_slot({name, "_s0"}, 0, e0);
    check_slot({name, "_s1"}, 1, e1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // All four inputs in one cycle from rr = 0: slots get 0,1 then 2,3.
  task automatic contention(input string name, input int base);
    idle();
    for (int i = 0; i < NI; i++) in_uops[i] = ev(base + i);
    tick();
    idle();
    check_pair({name, "_c1"}, none_c, none_c);
    tick();
    check_pair({name, "_c2"}, ev(base), ev(base + 1));
    tick();
    check_pair({name, "_c3"}, ev(base + 2), ev(base + 3));
    tick();
    check_pair({name, "_c4"}, none_c, none_c);
  endtask

  task automatic drive_all(input int s0, input int s1, input int s2, input int s3);
    in_uops[0] = ev(s0);
    in_uops[1] = ev(s1);
    in_uops[2] = ev(s2);
    in_uops[3] = ev(s3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, recv;
    logic [63:0] sum_in, sum_out;
    logic seen_busy3;
    none_c = '0;

    vecs[0] = '{2, 7'd5,   7'd10,  32'h0000_1234, 4'h0, 1'b0, 1'b0, 7'd0,  1'b1};
    vecs[1] = '{0, 7'h7f,  7'd0,   32'hffff_ffff, 4'hf, 1'b1, 1'b0, 7'd0,  1'b1};
    vecs[2] = '{3, 7'd3,   7'd1,   32'hdead_beef, 4'h5, 1'b0, 1'b1, 7'd126, 1'b0};
    vecs[3] = '{1, 7'd9,   7'd125, 32'h0000_5a5a, 4'ha, 1'b0, 1'b1, 7'd1,  1'b1};
    vecs[4] = '{0, 7'd2,   7'd25,  32'h0000_0077, 4'h1, 1'b1, 1'b1, 7'd25, 1'b1};
    vecs[5] = '{2, 7'd4,   7'd26,  32'h0000_0088, 4'h2, 1'b0, 1'b1, 7'd25, 1'b0};

    do_reset();
    check_pair("reset", none_c, none_c);
    check("reset_busy", 64'(busy), 64'd0);

    for (int v = 0; v < 6; v++) begin
      RES_UOp exp;
      idle();
      in_uops[vecs[v].idx] = mk(vecs[v].tag, vecs[v].sqn, vecs[v].res, vecs[v].fl, vecs[v].dnc);
      branch.taken = vecs[v].br_taken;
      branch.sqN   = vecs[v].br_sqn;
      tick();
      idle();
      check_pair($sformatf("vec%0d_c1", v), none_c, none_c);
      tick();
      exp = vecs[v].exp_valid ? mk(vecs[v].tag, vecs[v].sqn, vecs[v].res, vecs[v].fl, vecs[v].dnc)
                              : none_c;
      check_pair($sformatf("vec%0d_c2", v), exp, none_c);
      tick();
      check_pair($sformatf("vec%0d_c3", v), none_c, none_c);
      check($sformatf("vec%0d_busy", v), 64'(busy), 64'd0);
    end

    // Flush: queue 1 gets 20,21,22; branch at 20 kills 21/22 with no grant spent on them.
    do_reset();
    drive_all(1, 20, 2, 3);
    tick();
    check_pair("fl_c1", none_c, none_c);
    check("fl_c1_busy", 64'(busy), 64'h0);
    drive_all(4, 21, 5, 6);
    tick();
    check_pair("fl_c2", ev(1), ev(20));
    check("fl_c2_busy", 64'(busy), 64'hc);
    drive_all(7, 22, 8, 9);
    tick();
    check_pair("fl_c3", ev(2), ev(3));
    check("fl_c3_busy", 64'(busy), 64'hf);
    idle();
    branch.taken = 1'b1;
    branch.sqN   = 7'd20;
    tick();
    idle();
    check_pair("fl_c4", ev(4), ev(5));
    check("fl_c4_busy", 64'(busy), 64'ha);
    tick();
    check_pair("fl_c5", ev(6), ev(7));
    check("fl_c5_busy", 64'(busy), 64'h0);
    tick();
    check_pair("fl_c6", ev(8), ev(9));
    tick();
    check_pair("fl_c7", none_c, none_c);

    // rr should be back at 0; two rounds confirm it stays there.
    contention("cont_a", 40);
    contention("cont_b", 44);

    // Killed on arrival versus an older uop under the same branch.
    idle();
    in_uops[0]   = ev(30);
    in_uops[1]   = ev(24);
    branch.taken = 1'b1;
    branch.sqN   = 7'd25;
    tick();
    idle();
    check_pair("koa_c1", none_c, none_c);
    tick();
    check_pair("koa_c2", ev(24), none_c);
    check("koa_busy", 64'(busy), 64'd0);
    tick();
    check_pair("koa_c3", none_c, none_c);

    // Issue honours busy; every result sent must come out exactly once.
    sent = 0; recv = 0; sum_in = 64'd0; sum_out = 64'd0; seen_busy3 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      idle();
      if (busy[3]) seen_busy3 = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (!busy[i]) begin
          in_uops[i] = mk(TAG_W'(sent), 7'd0, RES_W'(32'h1000 + sent * 7), 4'h0, 1'b0);
          sum_in = sum_in + 64'(32'h1000 + sent * 7);
          sent++;
        end
      end
      tick();
      for (int k = 0; k < NO; k++) begin
        if (out_uops[k].valid) begin
          recv++;
          sum_out = sum_out + 64'(out_uops[k].result);
        end
      end
    end
    idle();
    for (int c = 0; c < 40 && recv < sent; c++) begin
      tick();
      for (int k = 0; k < NO; k++) begin
        if (out_uops[k].valid) begin
          recv++;
          sum_out = sum_out + 64'(out_uops[k].result);
        end
      end
    end
    check("stress_count", 64'(recv), 64'(sent));
    check("stress_sum", sum_out, sum_in);
    check("stress_busy3_seen", 64'(seen_busy3), 64'd1);
    tick();
    check_pair("stress_idle", none_c, none_c);

    // Mid-operation reset with queued entries, rr = 2 and valid outputs.
    do_reset();
    drive_all(50, 51, 52, 53);
    tick();
    drive_all(60, 61, 62, 63);
    tick();
    check_pair("rst_pre", ev(50), ev(51));
    check("rst_pre_busy", 64'(busy), 64'hc);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_pair("rst_post", none_c, none_c);
    check("rst_post_busy", 64'(busy), 64'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check_pair($sformatf("rst_stale%0d", c), none_c, none_c);
    end
    contention("rst_cont", 70);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
